memo_trans_seq: RTL
===================

# memo_trans_seq

Run-level sequencer for the memory-transfer datapath. On a `start` pulse it fills memory A from `DataInA`, then walks A pairwise through the delay flop, adder, subber and comparator, writing one result per pair into memory B. Between runs it keeps both memories' internal address pointers aligned to 0, including after an abort. It replaces the free-running controller as the owner of `WEA/IncA/WEB/IncB` and adds a `start`/`busy`/`done`/`aborted` handshake.

## Interface
- `DEPTH_A`, default 8: memory A words; power of two, ≥4. `DEPTH_B` = `DEPTH_A/2` is a derived localparam.
- `CNT_W`, default 5: `counter` width; must hold `DEPTH_A`.
- `clock  in  1`: single clock, rising edge.
- `Reset  in  1`: asynchronous, active-high. The same net resets both memories' pointers.
- `start  in  1`: run request, sampled at the edge, honoured only in IDLE.
- `abort  in  1`: cancel request, sampled at the edge, honoured in LOAD/COMPUTE.
- `Sign  in  1`: comparator output; 1 selects `SUBOut`, 0 selects `ADDOut`.
- `WEA  out  1`: memory A write enable.
- `IncA  out  1`: memory A pointer increment.
- `WEB  out  1`: memory B write enable.
- `IncB  out  1`: memory B pointer increment.
- `sel_sub  out  1`: `DataInB` mux select, `= WEB & Sign`.
- `busy  out  1`: high in LOAD, COMPUTE and FLUSH.
- `done  out  1`: 1-cycle pulse on normal completion.
- `aborted  out  1`: 1-cycle pulse when an aborted run has realigned.
- `counter  out  CNT_W`: cycle index within the current phase.

## Operation
- States: IDLE, LOAD, COMPUTE, FLUSH, DONE. An internal `b_ptr` (log2 `DEPTH_B` bits) mirrors memory B's pointer.
- **IDLE**
  - All strobes 0, `counter` = 0.
  - `start & !abort` → LOAD.
  - `start & abort` → stay IDLE.
- **LOAD**
  - `WEA = IncA = 1` every cycle; one `DataInA` word is written per cycle.
  - `counter` runs 0..`DEPTH_A`-1, then → COMPUTE with `counter` = 0. Memory A's pointer has wrapped to 0.
- **COMPUTE**
  - `IncA = 1` every cycle, so A is at address `counter` and the delay flop holds word `counter`-1.
  - On odd `counter`: `WEB = IncB = 1`, and pair (word c-1, word c) is written to B.
  - After `counter` = `DEPTH_A`-1 → DONE. Both pointers are at 0.
- **DONE**: `done = 1` for one cycle, then → IDLE.
- **abort**
  - The cycle in which `abort` is sampled still issues its normal strobes.
  - Next state: if `counter` = `DEPTH_A`-1, → IDLE with `aborted` pulsed that cycle. Otherwise → FLUSH with `counter` + 1.
  - `abort` on the last COMPUTE cycle does not complete the run: no DONE, no `done`.
- **FLUSH**
  - `IncA = 1` until `counter` reaches `DEPTH_A`.
  - `IncB = 1` while `b_ptr` ≠ 0.
  - `WEA = WEB = 0` throughout.
  - Exit when both pointers are at 0 → IDLE, `aborted = 1` for one cycle.
  - By construction, remaining A steps ≥ remaining B steps.
- `start` outside IDLE and `abort` in IDLE/DONE are ignored.

## Timing
- Strobes, `busy`, `done`, `aborted` and `counter` are Moore outputs decoded from registered state, `counter` and `b_ptr`. They have no combinational path from `start`/`abort`.
- `sel_sub` is the only combinational input path: `Sign` → `sel_sub`, same cycle.
- With `start` sampled at edge E0 (default `DEPTH_A` = 8):
  - LOAD: cycles 1–8.
  - COMPUTE: cycles 9–16.
  - `done`: cycle 17.
  - IDLE: cycle 18.
  - Start-to-done latency is 2·`DEPTH_A`+1 cycles.
- Reset, asynchronous: all outputs 0, state IDLE, `counter` = 0, `b_ptr` = 0, immediately and mid-run. No `done` or `aborted` on exit from reset.
- `counter` is `CNT_W` bits, zero-extended. It resets to 0 on every phase entry.

## Structure
- Shared package `memo_trans_pkg` holds:
  - the state encoding enum (IDLE = 0);
  - `DEPTH_A_DEF` = 8 and `CNT_W_DEF` = 5;
  - the `SEL_ADD`/`SEL_SUB` constants.
- Sub-module `memo_trans_ptr_trk` contains `b_ptr` plus flush-completion detection (A and B aligned). Everything else is a single FSM + counter.

## Test plan
- **Normal run:** Reset, load `DataInA` = 1..8, `start` pulse at E0.
  - LOAD: `WEA`/`IncA` high in cycles 1–8.
  - COMPUTE: `WEB`/`IncB` high in cycles 10, 12, 14, 16.
  - `done` in cycle 17.
  - `busy` high for exactly 16 cycles.
- **Mux select:** drive `Sign` = 1,0,0,1 on the four `WEB` cycles.
  - `sel_sub` = 1,0,0,1 on those cycles, 0 on all others.
  - B holds SUB, ADD, ADD, SUB of the corresponding pairs.
- **Abort in LOAD:** assert `abort` in LOAD at `counter` = 3.
  - FLUSH: 4 cycles with `IncA` = 1, no `IncB`, no writes.
  - `aborted` pulses, `done` never does.
  - A second run writes A from address 0.
- **Abort in COMPUTE:** assert `abort` in COMPUTE at `counter` = 2 (1 B write done).
  - FLUSH: 5 cycles of `IncA`, with `IncB` in its first 3.
  - `aborted` pulses.
  - The next run's first B write goes to address 0.
- **Ignored requests:** `start` held throughout a run → exactly one run, one `done`. `start & abort` in IDLE → no state change.
- **Reset mid-run:** assert `Reset` in COMPUTE at `counter` = 5.
  - All outputs 0 asynchronously.
  - After release, a fresh `start` gives the same run and timing as the normal-run scenario.

Source files
------------

// File: rtl/memo_trans_seq_pkg.sv
// memo_trans_pkg: state encoding, default sizing and mux-select codes shared
// by the run-level sequencer, its pointer tracker and anything talking to them.
package memo_trans_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int DEPTH_A_DEF = 8;
    localparam int CNT_W_DEF   = 5;

    // DataInB mux codes: adder result or subber result
    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/memo_trans_seq_if.sv
// memo_trans_seq_if: run handshake plus memory strobes between a host/datapath
// (master side, issues start/abort and the comparator Sign) and the sequencer
// (slave side, answers with strobes, status and the phase counter).
interface memo_trans_seq_if #(
    parameter int CNT_W = memo_trans_pkg::CNT_W_DEF
) ();
    import memo_trans_pkg::*;

    logic             start;
    logic             abort;
    logic             Sign;
    logic             WEA;
    logic             IncA;
    logic             WEB;
    logic             IncB;
    logic             sel_sub;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] counter;

    modport master (
        output start, abort, Sign,
        input  WEA, IncA, WEB, IncB, sel_sub, busy, done, aborted, counter
    );

    modport slave (
        input  start, abort, Sign,
        output WEA, IncA, WEB, IncB, sel_sub, busy, done, aborted, counter
    );

endinterface

// File: rtl/memo_trans_seq_ptr_trk.sv
// memo_trans_ptr_trk: shadow of memory B's address pointer, plus detection of
// the flush step after which both memories' pointers sit at address 0 again.
module memo_trans_ptr_trk #(
    parameter int DEPTH_B = memo_trans_pkg::DEPTH_A_DEF / 2,
    parameter int B_W     = (DEPTH_B > 1) ? $clog2(DEPTH_B) : 1
) (
    input  logic clock,
    input  logic Reset,
    input  logic i_incB,
    input  logic i_aLast,
    output logic o_bBusy,
    output logic o_aligned
);
    import memo_trans_pkg::*;

    logic [B_W-1:0] r_b_ptr;
    logic [B_W-1:0] w_bPtrNext;

    // DEPTH_B is a power of two, so the natural wrap matches memory B's pointer
    assign w_bPtrNext = i_incB ? (r_b_ptr + 1'b1) : r_b_ptr;

    // follow every IncB the sequencer issues; reset together with the memories
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_b_ptr <= '0;
        end else begin
            r_b_ptr <= w_bPtrNext;
        end
    end

    assign o_bBusy   = (r_b_ptr != '0);
    assign o_aligned = i_aLast & (w_bPtrNext == '0);

endmodule

// File: rtl/memo_trans_seq.sv
// memo_trans_seq: fills memory A, walks it pairwise into memory B, and on
// abort steps both pointers back to address 0 before reporting 'aborted'.
// All status and strobes are decoded from registered state only; sel_sub is
// the one output with a same-cycle path from an input (Sign).
module memo_trans_seq #(
    parameter int DEPTH_A = memo_trans_pkg::DEPTH_A_DEF,
    parameter int CNT_W   = memo_trans_pkg::CNT_W_DEF
) (
    input  logic              clock,
    input  logic              Reset,
    memo_trans_seq_if.slave   bus
);
    import memo_trans_pkg::*;

    localparam int               DEPTH_B   = DEPTH_A / 2;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH_A - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_A);

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_counter;
    logic [CNT_W-1:0] w_counterNext;
    logic             r_aborted;
    logic             w_abortedNext;

    logic w_wea;
    logic w_incA;
    logic w_web;
    logic w_incB;
    logic w_bBusy;
    logic w_aligned;
    logic w_last;
    logic w_aLast;

    assign w_last  = (r_counter == LAST_CNT);
    assign w_aLast = (r_state == ST_FLUSH) & w_last & w_incA;

    memo_trans_ptr_trk #(
        .DEPTH_B (DEPTH_B)
    ) u_ptr_trk (
        .clock     (clock),
        .Reset     (Reset),
        .i_incB    (w_incB),
        .i_aLast   (w_aLast),
        .o_bBusy   (w_bBusy),
        .o_aligned (w_aligned)
    );

    // memory strobes per phase; B is written once per A pair, on the odd word
    always_comb begin
        w_wea  = 1'b0;
        w_incA = 1'b0;
        w_web  = 1'b0;
        w_incB = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_wea  = 1'b1;
                w_incA = 1'b1;
            end
            ST_COMPUTE: begin
                w_incA = 1'b1;
                w_web  = r_counter[0];
                w_incB = r_counter[0];
            end
            ST_FLUSH: begin
                w_incA = (r_counter < DEPTH_CNT);
                w_incB = w_bBusy;
            end
            default: begin
            end
        endcase
    end

    // phase sequencing; an abort still lets its own cycle's strobes go out
    always_comb begin
        w_stateNext   = r_state;
        w_counterNext = r_counter;
        w_abortedNext = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_counterNext = '0;
                if (bus.start && !bus.abort) begin
                    w_stateNext = ST_LOAD;
                end
            end
            ST_LOAD, ST_COMPUTE: begin
                if (bus.abort) begin
                    if (w_last) begin
                        w_stateNext   = ST_IDLE;
                        w_counterNext = '0;
                        w_abortedNext = 1'b1;
                    end else begin
                        w_stateNext   = ST_FLUSH;
                        w_counterNext = r_counter + 1'b1;
                    end
                end else if (w_last) begin
                    w_stateNext   = (r_state == ST_LOAD) ? ST_COMPUTE : ST_DONE;
                    w_counterNext = '0;
                end else begin
                    w_counterNext = r_counter + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (w_aligned) begin
                    w_stateNext   = ST_IDLE;
                    w_counterNext = '0;
                    w_abortedNext = 1'b1;
                end else begin
                    w_counterNext = r_counter + 1'b1;
                end
            end
            ST_DONE: begin
                w_stateNext   = ST_IDLE;
                w_counterNext = '0;
            end
            default: begin
                w_stateNext   = ST_IDLE;
                w_counterNext = '0;
            end
        endcase
    end

    // state, phase counter and the one-shot aborted flag
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_counter <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_counter <= w_counterNext;
            r_aborted <= w_abortedNext;
        end
    end

    assign bus.WEA     = w_wea;
    assign bus.IncA    = w_incA;
    assign bus.WEB     = w_web;
    assign bus.IncB    = w_incB;
    assign bus.sel_sub = (w_web & bus.Sign) ? SEL_SUB : SEL_ADD;
    assign bus.busy    = (r_state == ST_LOAD) || (r_state == ST_COMPUTE) ||
                         (r_state == ST_FLUSH);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.aborted = r_aborted;
    assign bus.counter = r_counter;

endmodule
